// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: combinational grant starting at r_ptr, pointer advances past each grant.
// Zero-latency grant; allow_req_i low suppresses all grants and freezes the pointer.
module round_robin_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       allow_req_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_addr_o,
    output logic                       gnt_addr_valid_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_cand_idx;
    int               w_cand;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first requester wins.
    always_comb begin
        w_found    = 1'b0;
        w_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = w_cand[IDX_W-1:0];
            if (!w_found && req_i[w_cand_idx]) begin
                w_found = 1'b1;
                w_idx   = w_cand_idx;
            end
        end
    end

    assign gnt_addr_valid_o = allow_req_i & w_found;
    assign gnt_addr_o       = w_idx;
    assign gnt_o            = gnt_addr_valid_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_idx) : '0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ptr <= '0;
        end else if (gnt_addr_valid_o) begin
            r_ptr <= (w_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_idx + IDX_W'(1);
        end
    end
endmodule

// File: rtl/rr_stream_mux.sv
// Round-robin N:1 stream mux with a single registered output stage; 1-cycle latency, 1 beat/cycle.
// Backpressure: inputs see ready only when the output register is empty or draining this cycle.
module rr_stream_mux #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   in_data_i,
    input  logic [NUM_REQ-1:0]                   in_valid_i,
    output logic [NUM_REQ-1:0]                   in_ready_o,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic [$clog2(NUM_REQ)-1:0]           out_src_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic                  w_can_load;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [IDX_W-1:0]      w_gnt_addr;
    logic                  w_gnt_vld;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0]      r_out_src;
    logic                  r_out_valid;

    assign w_can_load = !r_out_valid || out_ready_i;

    round_robin_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .allow_req_i     (w_can_load),
        .req_i           (in_valid_i),
        .gnt_o           (w_gnt),
        .gnt_addr_o      (w_gnt_addr),
        .gnt_addr_valid_o(w_gnt_vld)
    );

    // Reset gates ready directly so no handshake is visible while held in reset.
    assign in_ready_o = w_gnt & {NUM_REQ{arst_ni}};

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_gnt_vld) begin
            r_out_data  <= in_data_i[w_gnt_addr];
            r_out_src   <= w_gnt_addr;
            r_out_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data_o  = r_out_data;
    assign out_src_o   = r_out_src;
    assign out_valid_o = r_out_valid;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed and random checks of rr_stream_mux with NUM_REQ=4, DATA_WIDTH=8.
module tb_rr_stream_mux;
    logic            clk;
    logic            rst_n;
    logic [3:0][7:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [7:0]      out_data;
    logic [1:0]      out_src;
    logic            out_valid;
    logic            out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    rr_stream_mux #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
        .clk_i      (clk),
        .arst_ni    (rst_n),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_src_o  (out_src),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h44332211;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", out_data); end
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL reset_src got %0d want 0", out_src); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    endtask

    task automatic test_fairness;
        logic [1:0] s;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h13121110;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL fair_first_ready got %b want 0001", in_ready); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s = 2'(k % 4);
            n_cmp++; if (out_valid !== 1'b1 || out_src !== s || out_data !== (8'h10 + 8'(s))) begin
                n_bad++; $display("FAIL fair_beat%0d got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                                  k, out_valid, out_src, out_data, s, 8'h10 + 8'(s));
            end
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure;
        do_reset;
        in_valid = 4'b0100; in_data[2] = 8'hA5; out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_accept_ready got %b want 0100", in_ready); end
        @(negedge clk);
        in_data[2] = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2 || in_ready !== 4'b0000) begin
                n_bad++; $display("FAIL bp_hold%0d got v=%b data=%h src=%0d rdy=%b want v=1 data=a5 src=2 rdy=0000",
                                  k, out_valid, out_data, out_src, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_release_ready got %b want 0100", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            n_bad++; $display("FAIL bp_next_beat got v=%b data=%h want v=1 data=5a", out_valid, out_data);
        end
        in_valid = '0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h5A || out_src !== 2'd2) begin
            n_bad++; $display("FAIL bp_drain got v=%b data=%h src=%0d want v=0 data=5a src=2", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_throughput;
        do_reset;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL tput_idle got %b want 0", out_valid); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(k) || out_src !== 2'd1) begin
                    n_bad++; $display("FAIL tput_beat%0d got v=%b data=%h src=%0d want v=1 data=%h src=1",
                                      k, out_valid, out_data, out_src, 8'(k));
                end
            end
            if (k < 8) begin
                in_valid = 4'b0010; in_data[1] = 8'(k + 1);
            end else begin
                in_valid = '0;
            end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL tput_end got %b want 0", out_valid); end
    endtask

    task automatic test_wrap_skip;
        do_reset;
        out_ready = 1'b1; in_valid = 4'b0100; in_data = 32'hD3C2B1A0;
        @(negedge clk);
        in_valid = 4'b1010;
        #1;
        n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3 got %b want 1000", in_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (out_src !== 2'd3 || out_data !== 8'hD3 || in_ready !== 4'b0010) begin
            n_bad++; $display("FAIL wrap_after3 got src=%0d data=%h rdy=%b want src=3 data=d3 rdy=0010", out_src, out_data, in_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (out_src !== 2'd1 || out_data !== 8'hB1 || in_ready !== 4'b1000) begin
            n_bad++; $display("FAIL wrap_after1 got src=%0d data=%h rdy=%b want src=1 data=b1 rdy=1000", out_src, out_data, in_ready);
        end
        @(negedge clk);
        n_cmp++; if (out_src !== 2'd3) begin n_bad++; $display("FAIL wrap_third got src=%0d want 3", out_src); end
        in_valid = '0;
    endtask

    task automatic test_reset_midstream;
        do_reset;
        in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_bad++; $display("FAIL mid_pre got v=%b data=%h want v=1 data=11", out_valid, out_data);
        end
        in_valid = 4'b1110;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0 || in_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_reset got v=%b data=%h src=%0d rdy=%b want all 0", out_valid, out_data, out_src, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_gnt got %b want 0001", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h11) begin
            n_bad++; $display("FAIL mid_first_beat got v=%b src=%0d data=%h want v=1 src=0 data=11", out_valid, out_src, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_random;
        int         m_ptr;
        bit         m_valid;
        bit         can;
        int         g;
        int         idx;
        int         wait_cnt [4];
        logic [3:0] exp_rdy;
        logic [9:0] q [$];
        logic [9:0] item;
        do_reset;
        m_ptr = 0; m_valid = 1'b0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 1010; cyc++) begin
            if (cyc < 1000) begin
                in_valid  = 4'($urandom);
                for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = '0;
                out_ready = 1'b1;
            end
            #1;
            can = !m_valid || out_ready;
            g = -1;
            if (can) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && in_valid[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            n_cmp++; if (in_ready !== exp_rdy) begin
                n_bad++; $display("FAIL rand_ready cyc%0d got %b want %b", cyc, in_ready, exp_rdy);
            end
            n_cmp++; if (out_valid !== m_valid) begin
                n_bad++; $display("FAIL rand_valid cyc%0d got %b want %b", cyc, out_valid, m_valid);
            end
            if (m_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL rand_dup cyc%0d got src=%0d data=%h want no beat", cyc, out_src, out_data);
                end else begin
                    item = q.pop_front();
                    if ({out_src, out_data} !== item) begin
                        n_bad++; $display("FAIL rand_order cyc%0d got %h want %h", cyc, {out_src, out_data}, item);
                    end
                end
            end
            if (g >= 0) begin
                q.push_back({2'(g), in_data[g]});
                m_ptr = (g + 1) % 4;
                for (int i = 0; i < 4; i++) begin
                    if (i == g) wait_cnt[i] = 0;
                    else if (in_valid[i]) begin
                        wait_cnt[i]++;
                        n_cmp++; if (wait_cnt[i] > 4) begin
                            n_bad++; $display("FAIL rand_starve stream%0d waited %0d grants want <=4", i, wait_cnt[i]);
                        end
                    end else wait_cnt[i] = 0;
                end
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rand_loss got %0d pending v=%b want 0 pending v=0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_fairness;
        test_backpressure;
        test_throughput;
        test_wrap_skip;
        test_reset_midstream;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of input streams (legal range 2..64).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload width in bits.
REQ-003 SHALL have port clk_i, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_ni, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port in_data_i, input, NUM_REQ x DATA_WIDTH, payload per input stream.
REQ-006 SHALL have port in_valid_i, input, NUM_REQ bits, per-stream valid.
REQ-007 SHALL have port in_ready_o, output, NUM_REQ bits, per-stream ready, at most one bit high.
REQ-008 SHALL have port out_data_o, output, DATA_WIDTH bits, registered payload.
REQ-009 SHALL have port out_src_o, output, $clog2(NUM_REQ) bits, index of the stream that supplied out_data_o.
REQ-010 SHALL have port out_valid_o, output, 1 bit, output valid.
REQ-011 SHALL have port out_ready_i, input, 1 bit, downstream ready.

Function
REQ-012 SHALL accept a beat from stream i only in a cycle where in_valid_i[i] and in_ready_o[i] are both 1.
REQ-013 SHALL compute can_load = !out_valid_o || out_ready_i.
REQ-014 SHALL drive all in_ready_o low whenever can_load is 0.
REQ-015 SHALL, when can_load is 1, grant the first index with in_valid_i high, searching ptr, ptr+1, ... modulo NUM_REQ.
REQ-016 SHALL drive in_ready_o as a combinational function of in_valid_i, ptr, out_valid_o and out_ready_i, with no combinational path from in_data_i.
REQ-017 SHALL, on an accepted beat from stream g, register out_data_o <= in_data_i[g], out_src_o <= g, out_valid_o <= 1 on the next edge (latency 1 cycle).
REQ-018 SHALL update ptr <= (g+1) mod NUM_REQ on each accepted beat; ptr SHALL be unchanged otherwise.
REQ-019 SHALL, when out_valid_o && out_ready_i and no beat is accepted, clear out_valid_o on the next edge and hold out_data_o and out_src_o.
REQ-020 SHALL sustain one beat per cycle when out_ready_i is held high (simultaneous drain and load).
REQ-021 SHALL hold out_data_o, out_src_o and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-022 SHALL never drop or duplicate a beat; beats leave in acceptance order.
REQ-023 SHALL wrap ptr from NUM_REQ-1 to 0.
REQ-024 SHALL grant a lone requester on consecutive beats regardless of ptr.
REQ-025 SHALL ignore in_valid_i deassertion without a handshake; no state changes in that case.

Reset
REQ-026 SHALL, while arst_ni is 0, force out_valid_o=0, out_data_o=0, out_src_o=0 and ptr=0 asynchronously.
REQ-027 SHALL drive in_ready_o to all zeros while arst_ni is 0.
REQ-028 SHALL discard an in-flight output beat on reset mid-operation; first grant after release starts the search at index 0.

Structure
REQ-029 SHALL place no typedefs in a shared package; the only derived constant is the local index width $clog2(NUM_REQ).
REQ-030 SHALL instantiate round_robin_arbiter (NUM_REQ) as its single sub-module:
- allow_req_i = can_load
- req_i = in_valid_i
- gnt_addr_o / gnt_addr_valid_o provide g.
REQ-031 SHALL keep the output register, drain logic and data mux in rr_stream_mux itself.

Verification
REQ-032 Reset: assert arst_ni mid-stream with out_valid_o=1 -> out_valid_o, out_data_o and out_src_o read 0 immediately; in_ready_o=0.
REQ-033 Fairness: NUM_REQ=4, all valid, out_ready_i=1 -> out_src_o sequence 0,1,2,3,0,1 from the cycle after reset release.
REQ-034 Backpressure: out_ready_i=0 for 5 cycles with beat 0xA5 from stream 2 held:
- out_data_o=0xA5, out_src_o=2 stable throughout
- all in_ready_o=0.
REQ-035 Throughput: stream 1 alone valid, out_ready_i=1, data 1..8 -> 8 beats in 8 consecutive cycles, in order, out_src_o=1.
REQ-036 Wrap/skip: ptr=3, only streams 1 and 3 valid -> grant 3 then 1, then 3.
REQ-037 Random: random in_valid_i/out_ready_i for 1000 cycles -> scoreboard shows no loss, duplication or reorder; no stream waits more than NUM_REQ grants while valid.
